// File: rtl/data_mem_dump_ctrl.sv
// Debug dump sequencer: walks every data-memory word through the debug port and
// streams it to the UART transmitter one byte at a time, most-significant byte first.
module data_mem_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_mem_word,
  input  logic                  i_tx_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_next;
  logic [1:0]            byte_cnt;
  logic [1:0]            byte_cnt_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= S_IDLE;
      word_q   <= '0;
      byte_cnt <= '0;
      addr     <= '0;
    end else begin
      state    <= state_next;
      word_q   <= word_next;
      byte_cnt <= byte_cnt_next;
      addr     <= addr_next;
    end
  end

  // The outgoing byte is always the top of the shift register, so WAIT holds it
  // stable for the UART without a separate output register.
  always_comb begin
    state_next    = state;
    word_next     = word_q;
    byte_cnt_next = byte_cnt;
    addr_next     = addr;
    o_tx_start    = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;

    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          addr_next  = '0;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        word_next     = i_mem_word;
        byte_cnt_next = '0;
        state_next    = S_SEND;
      end

      S_SEND: begin
        o_tx_start = 1'b1;
        state_next = S_WAIT;
      end

      S_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt == 2'd3) begin
            state_next = S_NEXT;
          end else begin
            word_next     = word_q << 8;
            byte_cnt_next = byte_cnt + 2'd1;
            state_next    = S_SEND;
          end
        end
      end

      // The address stops at the last word instead of wrapping back to zero.
      S_NEXT: begin
        if (addr == LAST_ADDR) begin
          state_next = S_DONE;
        end else begin
          addr_next  = addr + 1'b1;
          state_next = S_LOAD;
        end
      end

      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_mem_addr = addr;
  assign o_tx_data  = word_q[DATA_WIDTH-1 -: 8];

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// Scoreboard bench for data_mem_dump_ctrl: expected bytes are queued when a dump is
// requested, and a monitor checks every o_tx_start byte against the queue.
module tb_data_mem_dump_ctrl;

  typedef struct {
    logic [7:0] data;
    logic [4:0] addr;
  } exp_t;

  logic        clock;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_mem_word;
  logic        i_tx_done;
  logic [4:0]  o_mem_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_busy;
  logic        o_done;

  logic [31:0] mem [32];
  exp_t        expQ [$];

  int checks      = 0;
  int errors      = 0;
  int txCount     = 0;
  int doneCount   = 0;
  bit txAuto      = 1'b1;
  int txLatency   = 1;
  int txCountdown = 0;
  bit busyCheckPending = 1'b0;

  data_mem_dump_ctrl #(
    .DATA_WIDTH(32),
    .MEM_DEPTH (32),
    .ADDR_WIDTH(5)
  ) dut (
    .i_clock   (clock),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_mem_word(i_mem_word),
    .i_tx_done (i_tx_done),
    .o_mem_addr(o_mem_addr),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign i_mem_word = mem[o_mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [4:0] addr, input logic [7:0] b3, input logic [7:0] b2,
                          input logic [7:0] b1, input logic [7:0] b0);
    expQ.push_back('{b3, addr});
    expQ.push_back('{b2, addr});
    expQ.push_back('{b1, addr});
    expQ.push_back('{b0, addr});
  endtask

  // Ramp memory: word i = i * 0x01010101, so every byte of word i equals i.
  task automatic pushRamp(input int firstWord, input int lastWord);
    for (int w = firstWord; w <= lastWord; w++) begin
      pushWord(5'(w), 8'(w), 8'(w), 8'(w), 8'(w));
    end
  endtask

  // Pulses i_start for one cycle; returns #1 into the cycle after the sampling edge.
  task automatic applyStimulus();
    @(posedge clock);
    #1 i_start = 1'b1;
    @(posedge clock);
    #1 i_start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input int doneBefore);
    int n = 0;
    while (doneCount == doneBefore && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("done_within_budget", 32'(doneCount > doneBefore), 32'd1);
  endtask

  task automatic waitAddr(input logic [4:0] target, input int budget);
    int n = 0;
    while (o_mem_addr !== target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("addr_reached", 32'(o_mem_addr), 32'(target));
  endtask

  task automatic waitTx(input int target, input int budget);
    int n = 0;
    while (txCount < target && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    checkOutput("tx_count_reached", 32'(txCount >= target), 32'd1);
  endtask

  // Monitor: pops one expected byte per o_tx_start and tracks o_done/o_busy.
  initial begin
    forever begin
      @(negedge clock);
      if (i_reset) begin
        busyCheckPending = 1'b0;
      end else begin
        if (busyCheckPending) begin
          checkOutput("busy_after_done", 32'(o_busy), 32'd0);
          busyCheckPending = 1'b0;
        end
        if (o_tx_start) begin
          exp_t e;
          txCount++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_tx: got byte 0x%0h, want no transfer", o_tx_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("tx_byte", 32'(o_tx_data), 32'(e.data));
            checkOutput("tx_addr", 32'(o_mem_addr), 32'(e.addr));
          end
        end
        if (o_done) begin
          doneCount++;
          checkOutput("busy_with_done", 32'(o_busy), 32'd1);
          busyCheckPending = 1'b1;
        end
      end
    end
  end

  // UART TX model: answers each o_tx_start with a one-cycle i_tx_done after txLatency cycles.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (txAuto) begin
        i_tx_done = 1'b0;
        if (txCountdown > 0) begin
          txCountdown--;
          if (txCountdown == 0) i_tx_done = 1'b1;
        end
        if (o_tx_start) txCountdown = txLatency;
      end
    end
  end

  initial begin
    int busyHigh;
    int bad;
    i_reset   = 1'b1;
    i_start   = 1'b0;
    i_tx_done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h0101_0101;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;
    checkOutput("reset_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("reset_tx_data", 32'(o_tx_data), 32'd0);
    checkOutput("reset_tx_start", 32'(o_tx_start), 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    busyHigh = 0;
    repeat (20) begin
      @(negedge clock);
      if (o_busy !== 1'b0) busyHigh++;
    end
    checkOutput("idle_busy_cycles", 32'(busyHigh), 32'd0);

    // Single-word byte order with a slow transmitter
    $display("[TB] byte order test");
    mem[0] = 32'h1122_3344;
    pushWord(5'd0, 8'h11, 8'h22, 8'h33, 8'h44);
    pushRamp(1, 31);
    txLatency = 3;
    txCount   = 0;
    doneCount = 0;
    applyStimulus();
    checkOutput("latency_load_no_start", 32'(o_tx_start), 32'd0);
    checkOutput("latency_load_busy", 32'(o_busy), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("latency_send_start", 32'(o_tx_start), 32'd1);
    checkOutput("latency_first_byte", 32'(o_tx_data), 32'h11);
    waitDone(2000, 0);
    checkOutput("order_tx_count", 32'(txCount), 32'd128);
    checkOutput("order_queue_empty", 32'(expQ.size()), 32'd0);

    // Full dump at minimum handshake latency
    $display("[TB] full dump test");
    mem[0]    = 32'h0;
    txLatency = 1;
    txCount   = 0;
    doneCount = 0;
    pushRamp(0, 31);
    applyStimulus();
    waitDone(1000, 0);
    repeat (3) @(negedge clock);
    checkOutput("full_tx_count", 32'(txCount), 32'd128);
    checkOutput("full_done_count", 32'(doneCount), 32'd1);
    checkOutput("full_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("full_addr_no_wrap", 32'(o_mem_addr), 32'd31);

    // Handshake robustness: coincident done ignored, long wait tolerated
    $display("[TB] handshake test");
    mem[0] = 32'hA5C3_0F96;
    txAuto = 1'b0;
    i_tx_done = 1'b0;
    expQ.push_back('{8'hA5, 5'd0});
    expQ.push_back('{8'hC3, 5'd0});
    applyStimulus();
    @(posedge clock);
    #1;
    checkOutput("hs_send_start", 32'(o_tx_start), 32'd1);
    i_tx_done = 1'b1;
    @(posedge clock);
    #1 i_tx_done = 1'b0;
    bad = 0;
    repeat (50) begin
      if (o_tx_start !== 1'b0 || o_busy !== 1'b1 || o_tx_data !== 8'hA5) bad++;
      @(posedge clock);
      #1;
    end
    checkOutput("hs_wait_stable_cycles_bad", 32'(bad), 32'd0);
    i_tx_done = 1'b1;
    @(posedge clock);
    #1 i_tx_done = 1'b0;
    checkOutput("hs_advance_start", 32'(o_tx_start), 32'd1);
    checkOutput("hs_advance_byte", 32'(o_tx_data), 32'hC3);
    @(posedge clock);
    #1 i_reset = 1'b1;
    @(posedge clock);
    #1 i_reset = 1'b0;
    checkOutput("hs_queue_empty", 32'(expQ.size()), 32'd0);
    expQ.delete();
    txAuto = 1'b1;
    txCountdown = 0;

    // Ignored restart at word 5
    $display("[TB] ignored restart test");
    mem[0]    = 32'h0;
    txCount   = 0;
    doneCount = 0;
    pushRamp(0, 31);
    applyStimulus();
    waitAddr(5'd5, 200);
    @(posedge clock);
    #1 i_start = 1'b1;
    @(posedge clock);
    #1 i_start = 1'b0;
    waitDone(1000, 0);
    repeat (3) @(negedge clock);
    checkOutput("restart_tx_count", 32'(txCount), 32'd128);
    checkOutput("restart_done_count", 32'(doneCount), 32'd1);
    checkOutput("restart_queue_empty", 32'(expQ.size()), 32'd0);

    // Reset mid-dump at word 10, byte 2
    $display("[TB] mid-dump reset test");
    txCount   = 0;
    doneCount = 0;
    pushRamp(0, 9);
    expQ.push_back('{8'h0A, 5'd10});
    expQ.push_back('{8'h0A, 5'd10});
    expQ.push_back('{8'h0A, 5'd10});
    applyStimulus();
    waitTx(43, 1000);
    @(posedge clock);
    #1 i_reset = 1'b1;
    @(posedge clock);
    #1 i_reset = 1'b0;
    checkOutput("midreset_busy", 32'(o_busy), 32'd0);
    checkOutput("midreset_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("midreset_tx_start", 32'(o_tx_start), 32'd0);
    checkOutput("midreset_tx_data", 32'(o_tx_data), 32'd0);
    checkOutput("midreset_done", 32'(o_done), 32'd0);
    repeat (5) @(negedge clock);
    checkOutput("midreset_no_done", 32'(doneCount), 32'd0);
    checkOutput("midreset_queue_empty", 32'(expQ.size()), 32'd0);
    expQ.delete();
    txCountdown = 0;

    mem[0] = 32'hDEAD_BEEF;
    pushWord(5'd0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    pushRamp(1, 31);
    applyStimulus();
    @(posedge clock);
    #1;
    checkOutput("after_reset_first_byte", 32'(o_tx_data), 32'hDE);
    checkOutput("after_reset_first_addr", 32'(o_mem_addr), 32'd0);
    waitDone(1000, 0);
    repeat (3) @(negedge clock);
    checkOutput("after_reset_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
